// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure declarations: no latency, no flow control.
package fetch_unit_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch stage.
// master = fetch unit, slave = its environment (branch unit, imem, decode).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO of {pc, instr}; an entry pushed at edge N is at dout after edge N.
// Push is dropped when full unless a pop frees the slot in the same cycle; pop on empty is ignored.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: one imem read in flight, response -> queue -> decode, entry visible the cycle after the response.
// Requests only while the queue has room for the returning word; decode backpressure stalls fetch, never drops.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = 2 * XLEN;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tag_q;
  logic            req_vld_q;

  logic            req_fire;
  logic            req_room;
  logic            rdr_to_drop;
  logic            q_push;
  logic            q_pop;
  logic            q_flush;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   cnt_nxt;
  logic [EW-1:0]   q_din;
  logic [EW-1:0]   q_dout;

  assign req_fire = req_vld_q && bus.imem_req_ready;
  assign q_flush  = bus.redirect_valid;
  assign q_pop    = !q_empty && bus.out_ready;
  assign q_push   = (state_q == FETCH_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid
                    && (!q_full || q_pop);
  assign q_din    = {tag_q, bus.imem_rsp_data};
  assign cnt_nxt  = q_flush ? '0 : (q_count + CW'(q_push) - CW'(q_pop));
  assign req_room = (cnt_nxt < CW'(QDEPTH));

  // A fetch still owed by memory after the redirect must be swallowed; one that
  // completes in the redirect cycle itself is already gone, so no DROP needed.
  assign rdr_to_drop = ((state_q != FETCH_IDLE) && !bus.imem_rsp_valid) || req_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_PC;
      tag_q     <= RESET_PC;
      req_vld_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q      <= bus.redirect_pc & ~XLEN'(3);
      state_q   <= rdr_to_drop ? FETCH_DROP : FETCH_IDLE;
      req_vld_q <= !rdr_to_drop;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (req_fire) begin
            state_q   <= FETCH_WAIT;
            tag_q     <= pc_q;
            pc_q      <= pc_q + XLEN'(4);
            req_vld_q <= 1'b0;
          end else begin
            req_vld_q <= req_room;
          end
        end
        FETCH_WAIT, FETCH_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_q   <= FETCH_IDLE;
            req_vld_q <= req_room;
          end
        end
        default: begin
          state_q   <= FETCH_IDLE;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (q_flush),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.imem_req_valid = req_vld_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = !q_empty;
  assign bus.out_instr      = q_empty ? XLEN'(INSTR_NOP) : q_dout[XLEN-1:0];
  assign bus.out_pc         = q_empty ? '0 : q_dout[EW-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table after reset plus hand-written redirect,
// backpressure, stall, wrap and reset-in-flight sequences against a small imem model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus_a ();
  fetch_unit_if #(.XLEN(32)) bus_b ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;

  int          lat      = 1;
  bit          rdy_ctrl = 1'b1;
  logic [31:0] salt     = 32'h0;
  int          fire_cnt = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_b_pc[$];

  bit          a_fire = 1'b0, a_pend = 1'b0, b_fire = 1'b0;
  int          a_left = 0;
  logic [31:0] a_addr = 32'h0, a_salt = 32'h0, b_addr = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory for both DUTs plus output monitors, all acting on the falling edge.
  initial begin
    bus_a.imem_req_ready = 1'b0; bus_a.imem_rsp_valid = 1'b0; bus_a.imem_rsp_data = '0;
    bus_b.imem_req_ready = 1'b1; bus_b.imem_rsp_valid = 1'b0; bus_b.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      bus_a.imem_rsp_valid = 1'b0;
      if (a_fire) begin
        a_pend = 1'b1;
        a_left = lat;
      end
      if (a_pend) begin
        a_left--;
        if (a_left == 0) begin
          a_pend = 1'b0;
          bus_a.imem_rsp_valid = 1'b1;
          bus_a.imem_rsp_data  = word(a_addr) ^ a_salt;
        end
      end
      bus_a.imem_req_ready = rdy_ctrl;
      a_fire = bus_a.imem_req_valid && rdy_ctrl;
      if (a_fire) begin
        a_addr = bus_a.imem_req_addr;
        a_salt = salt;
      end
      bus_b.imem_rsp_valid = b_fire;
      bus_b.imem_rsp_data  = word(b_addr);
      b_fire = bus_b.imem_req_valid;
      b_addr = bus_b.imem_req_addr;
      if (!rst) begin
        fire_cnt = 0;
        got_pc.delete(); got_instr.delete(); got_b_pc.delete();
      end else begin
        if (a_fire) fire_cnt++;
        if (bus_a.out_valid && bus_a.out_ready) begin
          got_pc.push_back(bus_a.out_pc);
          got_instr.push_back(bus_a.out_instr);
        end
        if (bus_b.out_valid && bus_b.out_ready) got_b_pc.push_back(bus_b.out_pc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && got_pc.size() < n; i++) tick();
    if (got_pc.size() < n) timeout(nm);
  endtask

  task automatic wait_fire_at(input logic [31:0] addr, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = bus_a.imem_req_valid && bus_a.imem_req_ready && (bus_a.imem_req_addr == addr);
    end
    if (!seen) timeout(nm);
  endtask

  typedef struct {
    logic        req_v;
    logic [31:0] addr;
    logic        out_v;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Cycle C0 is the first cycle after reset release; 1-cycle memory, decode always ready.
    tbl[0] = '{1'b0, 32'h00, 1'b0, 32'h0, 32'h0000_0013};
    tbl[1] = '{1'b1, 32'h00, 1'b0, 32'h0, 32'h0000_0013};
    tbl[2] = '{1'b0, 32'h04, 1'b0, 32'h0, 32'h0000_0013};
    tbl[3] = '{1'b1, 32'h04, 1'b1, 32'h0, 32'h5A5A_0000};
    tbl[4] = '{1'b0, 32'h08, 1'b0, 32'h0, 32'h0000_0013};
    tbl[5] = '{1'b1, 32'h08, 1'b1, 32'h4, 32'h5A5A_0004};
    tbl[6] = '{1'b0, 32'h0C, 1'b0, 32'h0, 32'h0000_0013};
    tbl[7] = '{1'b1, 32'h0C, 1'b1, 32'h8, 32'h5A5A_0008};
    tbl[8] = '{1'b0, 32'h10, 1'b0, 32'h0, 32'h0000_0013};
    tbl[9] = '{1'b1, 32'h10, 1'b1, 32'hC, 32'h5A5A_000C};

    bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0; bus_a.out_ready = 1'b1;
    bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0; bus_b.out_ready = 1'b1;

    // Steady-state stream, checked cycle by cycle.
    lat = 1; rdy_ctrl = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("c%0d_req_valid", i), 32'(bus_a.imem_req_valid), 32'(tbl[i].req_v));
      chk($sformatf("c%0d_req_addr", i),  bus_a.imem_req_addr,         tbl[i].addr);
      chk($sformatf("c%0d_out_valid", i), 32'(bus_a.out_valid),      32'(tbl[i].out_v));
      chk($sformatf("c%0d_out_pc", i),    bus_a.out_pc,                tbl[i].pc);
      chk($sformatf("c%0d_out_instr", i), bus_a.out_instr,             tbl[i].instr);
    end

    // Decode stalled: queue fills with PC 0 and 4, no third request.
    bus_a.out_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
    chk("bp_head_pc", bus_a.out_pc, 32'h0);
    chk("bp_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
    chk("bp_fire_cnt", 32'(fire_cnt), 32'd2);
    step();
    bus_a.out_ready = 1'b1;
    wait_got(3, 40, "bp_drain");
    chk("bp_pc0", got_pc[0], 32'h0);
    chk("bp_pc1", got_pc[1], 32'h4);
    chk("bp_pc2", got_pc[2], 32'h8);
    chk("bp_instr2", got_instr[2], 32'h5A5A_0008);

    // Redirect while the PC 8 fetch is outstanding.
    lat = 3;
    do_reset();
    wait_fire_at(32'h8, 60, "rd_fire8");
    step();
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 32'h0000_0103;
    step();
    bus_a.redirect_valid = 1'b0;
    tick();
    chk("rd_req_valid_drop", 32'(bus_a.imem_req_valid), 32'd0);
    chk("rd_req_addr", bus_a.imem_req_addr, 32'h100);
    chk("rd_out_valid", 32'(bus_a.out_valid), 32'd0);
    wait_got(4, 60, "rd_collect");
    chk("rd_pc1", got_pc[1], 32'h4);
    chk("rd_pc2", got_pc[2], 32'h100);
    chk("rd_instr2", got_instr[2], 32'h5A5A_0100);
    chk("rd_pc3", got_pc[3], 32'h104);

    // Memory not ready for 3 cycles, then 4-cycle latency.
    rdy_ctrl = 1'b0; lat = 4;
    do_reset();
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall%0d_req_valid", i), 32'(bus_a.imem_req_valid), 32'd1);
      chk($sformatf("stall%0d_req_addr", i), bus_a.imem_req_addr, 32'h0);
    end
    step();
    rdy_ctrl = 1'b1;
    wait_got(3, 80, "lat4_collect");
    chk("lat4_pc0", got_pc[0], 32'h0);
    chk("lat4_instr0", got_instr[0], 32'h5A5A_0000);
    chk("lat4_pc1", got_pc[1], 32'h4);
    chk("lat4_instr1", got_instr[1], 32'h5A5A_0004);
    chk("lat4_pc2", got_pc[2], 32'h8);
    chk("lat4_instr2", got_instr[2], 32'h5A5A_0008);

    // PC wrap on the second instance.
    lat = 1;
    do_reset();
    for (int i = 0; i < 30 && got_b_pc.size() < 2; i++) tick();
    if (got_b_pc.size() < 2) timeout("wrap_collect");
    chk("wrap_pc0", got_b_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", got_b_pc[1], 32'h0000_0000);

    // Reset while a fetch is outstanding; its response lands after release.
    lat = 3; bus_a.out_ready = 1'b0; salt = 32'h0000_FFF0;
    do_reset();
    wait_fire_at(32'h0, 30, "rst_fire0");
    step();
    rst = 1'b0;
    salt = 32'h0;
    step();
    tick();
    chk("rst_mid_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_mid_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
    chk("rst_mid_req_addr", bus_a.imem_req_addr, 32'h0);
    step();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_stale_ignored", 32'(bus_a.out_valid), 32'd0);
    repeat (12) tick();
    chk("rst_head_valid", 32'(bus_a.out_valid), 32'd1);
    chk("rst_head_pc", bus_a.out_pc, 32'h0);
    chk("rst_head_instr", bus_a.out_instr, 32'h5A5A_0000);
    chk("rst_fire_cnt", 32'(fire_cnt), 32'd2);
    step();
    bus_a.out_ready = 1'b1;
    wait_got(2, 40, "rst_drain");
    chk("rst_got_instr0", got_instr[0], 32'h5A5A_0000);
    chk("rst_got_pc1", got_pc[1], 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
